// File: rtl/hps_reset_sequencer.sv
// Sequences fabric reset requests into the HPS f2h cold/warm/debug reset inputs and boot strobes.
// Optional watchdog-driven requests are built when HPS_RST_WDOG_EN is defined.
module hps_reset_sequencer #(
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int WDOG_CYCLES    = 50000000,
    parameter int WDOG_MAX_FAILS = 3
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       cold_req,
    input  logic       warm_req,
    input  logic       debug_req,
    input  logic       boot_image_ready,
    input  logic       boot_image_fail,
    output logic       f2h_cold_reset_req_n,
    output logic       f2h_warm_reset_req_n,
    output logic       f2h_debug_reset_req_n,
    output logic       boot_from_fpga_ready,
    output logic       boot_from_fpga_on_failure,
    output logic       busy,
    output logic [1:0] last_cause
`ifdef HPS_RST_WDOG_EN
    ,
    input  logic       wdog_kick,
    output logic [1:0] wdog_fails
`endif
);

    localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_COLD  = 2'b01;
    localparam logic [1:0] CAUSE_WARM  = 2'b10;
    localparam logic [1:0] CAUSE_DEBUG = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ASSERT  = 2'b01,
        HOLDOFF = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pend_q, pend_d;
    logic [2:0]       rise;
    logic [2:0]       req_now;
    logic             cold_p1, warm_p1, debug_p1;
    logic             ready_p1, fail_p1;
    logic             start;
    logic [1:0]       sel;
    logic [1:0]       cause_d;
    logic             wdog_warm, wdog_cold;

    // Bit 0 cold, bit 1 warm, bit 2 debug; watchdog requests behave like fresh rises
    assign rise[0] = (cold_req  & ~cold_p1)  | wdog_cold;
    assign rise[1] = (warm_req  & ~warm_p1)  | wdog_warm;
    assign rise[2] = (debug_req & ~debug_p1);
    assign req_now = pend_q | rise;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = req_now;
        start   = 1'b0;
        sel     = CAUSE_NONE;
        case (state_q)
            IDLE: begin
                if (|req_now) begin
                    start   = 1'b1;
                    state_d = ASSERT;
                    cnt_d   = '0;
                    if (req_now[0]) begin
                        sel    = CAUSE_COLD;
                        pend_d = 3'b000;
                    end else if (req_now[1]) begin
                        sel       = CAUSE_WARM;
                        pend_d[1] = 1'b0;
                    end else begin
                        sel       = CAUSE_DEBUG;
                        pend_d[2] = 1'b0;
                    end
                end
            end
            ASSERT: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLDOFF_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        cause_d = start ? sel : last_cause;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q               <= IDLE;
            cnt_q                 <= '0;
            pend_q                <= 3'b000;
            cold_p1               <= 1'b0;
            warm_p1               <= 1'b0;
            debug_p1              <= 1'b0;
            ready_p1              <= 1'b0;
            fail_p1               <= 1'b0;
            last_cause            <= CAUSE_NONE;
            f2h_cold_reset_req_n  <= 1'b1;
            f2h_warm_reset_req_n  <= 1'b1;
            f2h_debug_reset_req_n <= 1'b1;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            pend_q                <= pend_d;
            cold_p1               <= cold_req;
            warm_p1               <= warm_req;
            debug_p1              <= debug_req;
            ready_p1              <= boot_image_ready;
            fail_p1               <= boot_image_fail;
            last_cause            <= cause_d;
            f2h_cold_reset_req_n  <= ~((state_d == ASSERT) && (cause_d == CAUSE_COLD));
            f2h_warm_reset_req_n  <= ~((state_d == ASSERT) && (cause_d == CAUSE_WARM));
            f2h_debug_reset_req_n <= ~((state_d == ASSERT) && (cause_d == CAUSE_DEBUG));
        end
    end

    assign busy = (state_q != IDLE);

    // Boot strobes must never be seen by the HPS while a cold reset is being requested
    assign boot_from_fpga_ready      = ready_p1 & f2h_cold_reset_req_n;
    assign boot_from_fpga_on_failure = fail_p1  & f2h_cold_reset_req_n;

`ifdef HPS_RST_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic            wdog_armed;
    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_timeout;

    assign wdog_timeout = wdog_armed & ~wdog_kick & (wdog_cnt == WD_W'(1));
    assign wdog_cold    = wdog_timeout & (wdog_fails == 2'(WDOG_MAX_FAILS - 1));
    assign wdog_warm    = wdog_timeout & ~wdog_cold;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wdog_armed <= 1'b0;
            wdog_cnt   <= '0;
            wdog_fails <= 2'b00;
        end else if (wdog_kick) begin
            wdog_armed <= 1'b1;
            wdog_cnt   <= WD_W'(WDOG_CYCLES);
            wdog_fails <= 2'b00;
        end else begin
            if (wdog_armed) begin
                if (wdog_timeout) begin
                    wdog_cnt <= WD_W'(WDOG_CYCLES);
                    if (wdog_cold)
                        wdog_fails <= 2'b00;
                    else if (wdog_fails != 2'b11)
                        wdog_fails <= wdog_fails + 2'b01;
                end else begin
                    wdog_cnt <= wdog_cnt - 1'b1;
                end
            end
            // A cold pulse restarts the HPS, so wait for fresh kicks before watching again
            if (start && (sel == CAUSE_COLD))
                wdog_armed <= 1'b0;
        end
    end
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = ^{WDOG_CYCLES, WDOG_MAX_FAILS};
    assign wdog_warm = 1'b0;
    assign wdog_cold = 1'b0;
`endif

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Randomized bench for hps_reset_sequencer against a pulse-window reference model.
// Define HPS_RST_WDOG_EN to add the watchdog escalation scenario.
module tb_hps_reset_sequencer;

    localparam int P = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset_reset_n;
    logic       cold_req, warm_req, debug_req;
    logic       boot_image_ready, boot_image_fail;
    logic       f2h_cold_reset_req_n, f2h_warm_reset_req_n, f2h_debug_reset_req_n;
    logic       boot_from_fpga_ready, boot_from_fpga_on_failure;
    logic       busy;
    logic [1:0] last_cause;
`ifdef HPS_RST_WDOG_EN
    logic       wdog_kick = 1'b0;
    logic [1:0] wdog_fails;
`endif

    always #5 clk = ~clk;

    hps_reset_sequencer #(
        .PULSE_CYCLES   (P),
        .HOLDOFF_CYCLES (H),
        .WDOG_CYCLES    (20),
        .WDOG_MAX_FAILS (3)
    ) dut (
        .clk_clk                   (clk),
        .reset_reset_n             (reset_reset_n),
        .cold_req                  (cold_req),
        .warm_req                  (warm_req),
        .debug_req                 (debug_req),
        .boot_image_ready          (boot_image_ready),
        .boot_image_fail           (boot_image_fail),
        .f2h_cold_reset_req_n      (f2h_cold_reset_req_n),
        .f2h_warm_reset_req_n      (f2h_warm_reset_req_n),
        .f2h_debug_reset_req_n     (f2h_debug_reset_req_n),
        .boot_from_fpga_ready      (boot_from_fpga_ready),
        .boot_from_fpga_on_failure (boot_from_fpga_on_failure),
        .busy                      (busy),
        .last_cause                (last_cause)
`ifdef HPS_RST_WDOG_EN
        ,
        .wdog_kick                 (wdog_kick),
        .wdog_fails                (wdog_fails)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: each serviced request owns a window of edges [start, start+P) low
    // and [start, start+P+H) busy; the next selection may happen from edge start+P+H+1.
    int m_edge, m_start, m_free, m_cause, m_last;
    bit m_prev[3];
    bit m_pend[3];
    bit m_ready, m_fail;

    function automatic void model_reset();
        m_edge  = -1;
        m_start = -1000;
        m_free  = 0;
        m_cause = 0;
        m_last  = 0;
        m_ready = 1'b0;
        m_fail  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input bit c, input bit w, input bit d, input bit rdy, input bit fl);
        bit req[3];
        bit done;
        req[0] = c;
        req[1] = w;
        req[2] = d;
        m_edge++;
        for (int i = 0; i < 3; i++) begin
            if (req[i] && !m_prev[i])
                m_pend[i] = 1'b1;
            m_prev[i] = req[i];
        end
        done = 1'b0;
        if (m_edge >= m_free) begin
            for (int i = 0; i < 3; i++) begin
                if (!done && m_pend[i]) begin
                    done    = 1'b1;
                    m_start = m_edge;
                    m_cause = i + 1;
                    m_last  = i + 1;
                    m_free  = m_edge + P + H + 1;
                    m_pend[i] = 1'b0;
                    if (i == 0) begin
                        m_pend[1] = 1'b0;
                        m_pend[2] = 1'b0;
                    end
                end
            end
        end
        m_ready = rdy;
        m_fail  = fl;
    endfunction

    task automatic check_outputs();
        bit in_pulse, in_busy, cold_n;
        in_pulse = (m_edge >= m_start) && (m_edge < m_start + P);
        in_busy  = (m_edge >= m_start) && (m_edge < m_start + P + H);
        cold_n   = !(in_pulse && m_cause == 1);
        chk("cold_n",  f2h_cold_reset_req_n,  cold_n);
        chk("warm_n",  f2h_warm_reset_req_n,  !(in_pulse && m_cause == 2));
        chk("debug_n", f2h_debug_reset_req_n, !(in_pulse && m_cause == 3));
        chk("busy",    busy, in_busy);
        chk("last_cause", last_cause, m_last);
        chk("boot_ready", boot_from_fpga_ready, m_ready & cold_n);
        chk("boot_fail",  boot_from_fpga_on_failure, m_fail & cold_n);
    endtask

    task automatic cycle(input bit c, input bit w, input bit d, input bit rdy, input bit fl);
        cold_req         = c;
        warm_req         = w;
        debug_req        = d;
        boot_image_ready = rdy;
        boot_image_fail  = fl;
        @(posedge clk);
        model_edge(c, w, d, rdy, fl);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic apply_reset(input bit cold_hold);
        reset_reset_n    = 1'b0;
        cold_req         = cold_hold;
        warm_req         = 1'b0;
        debug_req        = 1'b0;
        boot_image_ready = 1'b0;
        boot_image_fail  = 1'b0;
        #1;
        chk("rst_cold_n",  f2h_cold_reset_req_n,  1'b1);
        chk("rst_warm_n",  f2h_warm_reset_req_n,  1'b1);
        chk("rst_debug_n", f2h_debug_reset_req_n, 1'b1);
        chk("rst_busy",    busy, 1'b0);
        chk("rst_cause",   last_cause, 2'b00);
        chk("rst_ready",   boot_from_fpga_ready, 1'b0);
        chk("rst_fail",    boot_from_fpga_on_failure, 1'b0);
        repeat (3) @(negedge clk);
        reset_reset_n = 1'b1;
        model_reset();
    endtask

    bit rc, rw, rd;
`ifdef HPS_RST_WDOG_EN
    int seen;
    int w_cause[3];
    int w_fails[3];
    bit prev_low, now_low;
`endif

    initial begin
        reset_reset_n    = 1'b1;
        cold_req         = 1'b0;
        warm_req         = 1'b0;
        debug_req        = 1'b0;
        boot_image_ready = 1'b0;
        boot_image_fail  = 1'b0;
        #2;
        apply_reset(1'b0);
        idle(3);

        // Single warm request
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(20);

        // Simultaneous rises: only cold is serviced
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(25);

        // Debug, then warm arriving during the debug holdoff
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(P + 2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(30);

        // Warm held high for 100 cycles
        for (int i = 0; i < 100; i++)
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(20);

        // Random traffic
        rc = 1'b0;
        rw = 1'b0;
        rd = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 31) == 0) rc = ~rc;
            if ($urandom_range(0, 11) == 0) rw = ~rw;
            if ($urandom_range(0, 11) == 0) rd = ~rd;
            cycle(rc, rw, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(20);

        // Reset in the middle of a debug pulse; nothing resumes afterwards
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(2);
        apply_reset(1'b0);
        idle(30);

        // Cold held through reset release counts as a fresh request
        apply_reset(1'b1);
        for (int i = 0; i < 30; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5);

`ifdef HPS_RST_WDOG_EN
        apply_reset(1'b0);
        wdog_kick = 1'b1;
        @(negedge clk);
        wdog_kick = 1'b0;
        seen     = 0;
        prev_low = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            now_low = !(f2h_cold_reset_req_n && f2h_warm_reset_req_n && f2h_debug_reset_req_n);
            if (now_low && !prev_low) begin
                if (seen < 3) begin
                    w_cause[seen] = last_cause;
                    w_fails[seen] = wdog_fails;
                end
                seen++;
            end
            prev_low = now_low;
        end
        chk("wdog_pulses", seen, 3);
        if (seen >= 3) begin
            chk("wdog_cause0", w_cause[0], 2);
            chk("wdog_fails0", w_fails[0], 1);
            chk("wdog_cause1", w_cause[1], 2);
            chk("wdog_fails1", w_fails[1], 2);
            chk("wdog_cause2", w_cause[2], 1);
            chk("wdog_fails2", w_fails[2], 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
